// File: rtl/pipe_pkg.sv
// Shared types and helpers for the fetch/decode skid register slice.
package pipe_pkg;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

   localparam int unsigned N_DEFAULT = 24;
   localparam logic [N_DEFAULT-1:0] NOP_DEFAULT = '0;

   // Bit offset of lane 'lane' inside a packed bus of 'width'-bit lanes.
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One instruction-bundle holding register with load and clear-to-NOP.
module pipe_slot #(
   parameter int unsigned W = 48
) (
   input  logic         clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [W-1:0] i_d,
   input  logic [W-1:0] i_nop,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Clear (reset or squash) wins over load.
   always_ff @(posedge clk) begin
      if (i_rst || i_clr) begin
         r_q <= i_nop;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/register_fd_skid.sv
// Fetch->decode pipeline register with valid/ready handshake, 2-entry skid
// buffer, flush with bubble injection and a saturating stall counter.
module register_fd_skid
   import pipe_pkg::*;
#(
   parameter int unsigned      N     = N_DEFAULT,
   parameter int unsigned      LANES = 2,
   parameter logic [N-1:0]     NOP   = N'(NOP_DEFAULT),
   parameter int unsigned      CW    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES*N-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*N-1:0] out_instr,
   output logic [CW-1:0]      stall_cnt
);

   skid_state_t        r_state;
   skid_state_t        w_next_state;
   logic [CW-1:0]      r_stall_cnt;

   logic [LANES*N-1:0] w_nop_bus;
   logic [LANES*N-1:0] w_main_q;
   logic [LANES*N-1:0] w_skid_q;
   logic [LANES*N-1:0] w_main_d;

   logic               w_in_fire;
   logic               w_out_fire;
   logic               w_main_load;
   logic               w_main_from_skid;
   logic               w_main_clr;
   logic               w_skid_load;
   logic               w_skid_clr;

   // Replicate the per-lane bubble value across all lanes.
   always_comb begin
      w_nop_bus = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         w_nop_bus[lane_lsb(k, N) +: N] = NOP;
      end
   end

   // Handshake outputs come straight from the state register.
   assign out_valid  = (r_state != EMPTY);
   assign in_ready   = (r_state != FULL);
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;
   assign w_main_d   = w_main_from_skid ? w_skid_q : in_instr;
   assign out_instr  = w_main_q;
   assign stall_cnt  = r_stall_cnt;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and slot control; main is cleared whenever it drains so
   // out_instr shows NOP while empty. Flush overrides everything, but an
   // out_fire in the same cycle has already been consumed downstream.
   always_comb begin
      w_next_state     = r_state;
      w_main_load      = 1'b0;
      w_main_from_skid = 1'b0;
      w_main_clr       = 1'b0;
      w_skid_load      = 1'b0;
      w_skid_clr       = 1'b0;
      unique case (r_state)
         EMPTY: begin
            if (w_in_fire) begin
               w_main_load  = 1'b1;
               w_next_state = ONE;
            end
         end
         ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_main_load = 1'b1;
            end else if (w_in_fire) begin
               w_skid_load  = 1'b1;
               w_next_state = FULL;
            end else if (w_out_fire) begin
               w_main_clr   = 1'b1;
               w_next_state = EMPTY;
            end
         end
         FULL: begin
            if (w_out_fire) begin
               w_main_load      = 1'b1;
               w_main_from_skid = 1'b1;
               w_skid_clr       = 1'b1;
               w_next_state     = ONE;
            end
         end
         default: begin
            w_next_state = EMPTY;
         end
      endcase
      if (flush) begin
         w_main_clr   = 1'b1;
         w_skid_clr   = 1'b1;
         w_next_state = EMPTY;
      end
   end

   // Saturating count of cycles where decode back-pressures a valid output.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CW'(1);
      end
   end

   pipe_slot #(.W(LANES*N)) u_main (
      .clk    (clk),
      .i_rst  (rst),
      .i_clr  (w_main_clr),
      .i_load (w_main_load),
      .i_d    (w_main_d),
      .i_nop  (w_nop_bus),
      .o_q    (w_main_q)
   );

   pipe_slot #(.W(LANES*N)) u_skid (
      .clk    (clk),
      .i_rst  (rst),
      .i_clr  (w_skid_clr),
      .i_load (w_skid_load),
      .i_d    (in_instr),
      .i_nop  (w_nop_bus),
      .o_q    (w_skid_q)
   );

endmodule
